// File: rtl/uart_pkg.sv
// Shared UART definitions: arbiter state encoding and link constants.
package uart_pkg;

  localparam int unsigned CLK_HZ      = 25_000_000;
  localparam int unsigned BAUD_RATE   = 9600;
  localparam int unsigned UART_DATA_W = 9;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEND      = 2'd1,
    WAIT_DONE = 2'd2
  } arb_state_t;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector. Returns the first set bit of
// req found by searching upward from rr_ptr, wrapping modulo NUM_REQ.
module rr_pick #(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] rr_ptr,
  output logic [$clog2(NUM_REQ)-1:0] winner,
  output logic                       any_valid
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  // Rotating priority search; the first hit from rr_ptr upward wins.
  always_comb begin
    logic [IDX_W-1:0] idx;
    winner    = '0;
    any_valid = 1'b0;
    idx       = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = IDX_W'((32'(rr_ptr) + k) % NUM_REQ);
      if (!any_valid && req[idx]) begin
        winner    = idx;
        any_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART transmitter among NUM_REQ message sources.
// Arbitration is per message with round-robin priority; words are forwarded
// one at a time using a tx_send / tx_done handshake.
// Optional: define UART_TX_ARB_WATCHDOG_EN to add a stall watchdog and the
// timeout_err output.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned DATA_W      = UART_DATA_W
`ifdef UART_TX_ARB_WATCHDOG_EN
  ,
  parameter int unsigned TIMEOUT_CYC = 65536
`endif
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  input  logic [NUM_REQ-1:0]          req_last,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic [DATA_W-1:0]           tx_data,
  output logic                        tx_send,
  input  logic                        tx_done,
  output logic [$clog2(NUM_REQ)-1:0]  grant_id,
  output logic                        busy
`ifdef UART_TX_ARB_WATCHDOG_EN
  ,
  output logic                        timeout_err
`endif
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  arb_state_t        state, state_next;
  logic [IDX_W-1:0]  rr_ptr;
  logic [IDX_W-1:0]  next_ptr;
  logic [IDX_W-1:0]  winner;
  logic              any_valid;
  logic              last_q;
  logic              grant_valid;
  logic [DATA_W-1:0] grant_data;
  logic              handshake;
  logic              abort;

  rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_pick (
    .req       (req_valid),
    .rr_ptr    (rr_ptr),
    .winner    (winner),
    .any_valid (any_valid)
  );

  // Select the owner's word and derive the accept handshake.
  always_comb begin
    grant_data = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_id == IDX_W'(i)) begin
        grant_data = req_data[i*DATA_W +: DATA_W];
      end
    end
    grant_valid = req_valid[grant_id];
    handshake   = (state == SEND) && grant_valid;
    next_ptr    = (grant_id == IDX_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
  end

`ifdef UART_TX_ARB_WATCHDOG_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC);

  logic [CNT_W-1:0] wd_cnt;

  always_comb begin
    abort = (state != IDLE) && (wd_cnt == CNT_W'(TIMEOUT_CYC - 1));
  end

  // Watchdog: counts idle-progress cycles while a message is open.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wd_cnt      <= '0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= abort;
      if ((state == IDLE) || handshake || ((state == WAIT_DONE) && tx_done) || abort) begin
        wd_cnt <= '0;
      end else begin
        wd_cnt <= wd_cnt + 1'b1;
      end
    end
  end
`else
  always_comb begin
    abort = 1'b0;
  end
`endif

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and the combinational ready output.
  always_comb begin
    state_next = state;
    req_ready  = '0;
    unique case (state)
      IDLE: begin
        if (any_valid) state_next = SEND;
      end
      SEND: begin
        req_ready[grant_id] = grant_valid;
        if (grant_valid) state_next = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (tx_done) state_next = last_q ? IDLE : SEND;
      end
      default: state_next = IDLE;
    endcase
    if (abort) begin
      state_next = IDLE;
      req_ready  = '0;
    end
  end

  // Grant, word capture, send pulse and round-robin pointer update.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      grant_id <= '0;
      busy     <= 1'b0;
      rr_ptr   <= '0;
      tx_data  <= '0;
      tx_send  <= 1'b0;
      last_q   <= 1'b0;
    end else begin
      tx_send <= 1'b0;
      if (abort) begin
        busy   <= 1'b0;
        rr_ptr <= next_ptr;
      end else begin
        unique case (state)
          IDLE: begin
            if (any_valid) begin
              grant_id <= winner;
              busy     <= 1'b1;
            end
          end
          SEND: begin
            if (handshake) begin
              tx_data <= grant_data;
              last_q  <= req_last[grant_id];
              tx_send <= 1'b1;
            end
          end
          WAIT_DONE: begin
            if (tx_done && last_q) begin
              rr_ptr <= next_ptr;
              busy   <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART transmitter (9-bit frame datapath, 9600 baud at 25 MHz) among NUM_REQ message sources, e.g. tower status, runway alerts and the debug console.
- Arbitrates at message granularity with round-robin priority.
- Forwards one word at a time to the transmitter with a send/done handshake.
- Sits between the requesters and the UART transmitter.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 9, width of one transmitted word.
- TIMEOUT_CYC, 65536, watchdog limit in clocks (used only with the optional feature).

Ports:
- clock  input  1  system clock, 25 MHz.
- reset_n  input  1  asynchronous, active-low reset.
- req_valid  input  NUM_REQ  requester i has a word on req_data slice i.
- req_data  input  NUM_REQ*DATA_W  packed words; slice i is [i*DATA_W +: DATA_W].
- req_last  input  NUM_REQ  word i is the final word of its message.
- req_ready  output  NUM_REQ  word accepted (valid&ready handshake).
- tx_data  output  DATA_W  word presented to the transmitter.
- tx_send  output  1  one-cycle pulse: start transmitting tx_data.
- tx_done  input  1  one-cycle pulse: transmitter finished the current word.
- grant_id  output  $clog2(NUM_REQ)  index of the current owner.
- busy  output  1  a message is in progress.

Behaviour:
- Reset values:
  - Outputs: req_ready=0, tx_data=0, tx_send=0, grant_id=0, busy=0.
  - Internal: rr_ptr=0, state=IDLE.
  - Reset mid-message abandons the message silently.
- States: IDLE, SEND, WAIT_DONE.
- IDLE:
  - If any req_valid is high, pick the first valid index searching upward from rr_ptr, modulo NUM_REQ.
  - Register it into grant_id, set busy=1, go to SEND.
  - Otherwise stay.
- SEND:
  - req_ready[grant_id] = req_valid[grant_id] (combinational); all other req_ready bits are 0.
  - On handshake: register tx_data from the granted slice, latch last_q=req_last[grant_id], pulse tx_send on the next cycle, go to WAIT_DONE.
  - If the owner drops req_valid mid-message, stay in SEND; the grant is held and no other requester is served.
- WAIT_DONE:
  - tx_data is held stable; the transmitter may sample it any time before tx_done.
  - On tx_done with last_q=1: rr_ptr = grant_id+1 (wraps to 0 after NUM_REQ-1), busy=0, go to IDLE.
  - On tx_done with last_q=0: go to SEND.
- tx_done outside WAIT_DONE is ignored.
- Latency:
  - req_valid rising in IDLE at cycle 0 → grant at cycle 1 → handshake in cycle 1 → tx_send high in cycle 2.
  - tx_done → next handshake possible the following cycle.
- Fairness: a requester that just finished has lowest priority in the next arbitration. The maximum wait is NUM_REQ-1 messages.
- A new message from the same requester never preempts: it re-enters arbitration only through IDLE.
- req_valid high with req_last high on the first word is a one-word message.

Optional Feature:
- Macro: UART_TX_ARB_WATCHDOG_EN.
- When defined:
  - Adds output timeout_err (1 bit, reset 0).
  - A counter runs in SEND and WAIT_DONE, clearing on each handshake and each tx_done.
  - On reaching TIMEOUT_CYC-1: abort the message, pulse timeout_err for one cycle, advance rr_ptr past the owner, go to IDLE.
- When undefined: no counter, no port; a stalled owner or a missing tx_done hangs the arbiter until reset.

Decomposition:
- Shared package uart_pkg: state enum arb_state_t {IDLE, SEND, WAIT_DONE}; localparams CLK_HZ=25_000_000, BAUD_RATE=9600, UART_DATA_W=9.
- One sub-module: rr_pick.
  - Purely combinational.
  - Inputs: req vector, rr_ptr. Outputs: winner index, any_valid.
  - Reusable by other shared-resource arbiters.

Test Plan:
- Single requester: req 2 sends 3 words 0x101,0x055,0x1AA (last on third); the model returns tx_done 5 cycles after each tx_send → tx_data sequence matches in order, grant_id=2 throughout, rr_ptr=3 afterwards, busy falls after the third tx_done.
- Round-robin: all 4 requesters issue one-word messages continuously from reset → grant order 0,1,2,3,0; no requester is served twice before the others.
- Mid-message stall: req 1 drops valid for 20 cycles between words while req 0 is valid → no tx_send during the gap, req_ready[0] stays 0, message 1 completes before req 0 is granted.
- Spurious tx_done: pulse tx_done in IDLE and in SEND → no state change, no extra tx_send.
- Reset mid-transmit: assert reset_n=0 in WAIT_DONE → all outputs 0 asynchronously; after release, req 3 valid → granted first (rr_ptr=0 search reaches 3).
- Watchdog (UART_TX_ARB_WATCHDOG_EN, TIMEOUT_CYC=16): withhold tx_done → timeout_err pulses 16 cycles after tx_send, state returns to IDLE, next grant skips the aborted requester.
